// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register busy scoreboard. After reset, a sweep clears the array one
// register per cycle, and the file is not usable until the sweep finishes.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  INIT  | clearing regs[idx] each cycle; ports gated, writes/allocs dropped
//  RUN   | file usable: writes, bypassed reads, scoreboard active
module regfile_mp #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int NWR    = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NRD*AW-1:0]   rs_addr,
   output logic [NRD*XLEN-1:0] rs_data,
   output logic [NRD-1:0]      rs_busy,
   input  logic [NWR-1:0]      we,
   input  logic [NWR*AW-1:0]   rd_addr,
   input  logic [NWR*XLEN-1:0] rd_data,
   input  logic                alloc_valid,
   input  logic [AW-1:0]       alloc_addr,
   output logic                ready
);

   typedef enum logic {INIT, RUN} state_t;

   state_t            state;
   logic [AW-1:0]     idx;
   logic [XLEN-1:0]   regs [NREGS];
   logic [NREGS-1:0]  busy;
   logic [AW-1:0]     rd_a;
   logic [XLEN-1:0]   rd_d;

   // Sweep sequencer: one register per cycle, ready rises with the last clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT;
         idx   <= '0;
         ready <= 1'b0;
      end else if (state == INIT) begin
         idx <= idx + 1'b1;
         if (idx == AW'(NREGS - 1)) begin
            state <= RUN;
            ready <= 1'b1;
         end
      end
   end

   // Data array has no reset; the sweep is its only initialisation.
   // Later write ports overwrite earlier ones, giving higher index priority.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         regs[idx] <= '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (we[j] && (rd_addr[j*AW +: AW] != '0))
               regs[rd_addr[j*AW +: AW]] <= rd_data[j*XLEN +: XLEN];
         end
      end
   end

   // Scoreboard: writes clear, then an allocation to the same register re-sets it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else if (state == INIT) begin
         busy <= '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (we[j])
               busy[rd_addr[j*AW +: AW]] <= 1'b0;
         end
         if (alloc_valid)
            busy[alloc_addr] <= 1'b1;
         busy[0] <= 1'b0;
      end
   end

   // Read ports: x0 and the not-ready state read as zero; bypass follows write priority
   always_comb begin
      rs_data = '0;
      rs_busy = '0;
      rd_a    = '0;
      rd_d    = '0;
      for (int i = 0; i < NRD; i++) begin
         rd_a = rs_addr[i*AW +: AW];
         rd_d = regs[rd_a];
         if (BYPASS != 0) begin
            for (int j = 0; j < NWR; j++) begin
               if (we[j] && (rd_addr[j*AW +: AW] == rd_a))
                  rd_d = rd_data[j*XLEN +: XLEN];
            end
         end
         if (ready && (rd_a != '0)) begin
            rs_data[i*XLEN +: XLEN] = rd_d;
            rs_busy[i]              = busy[rd_a];
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass on and off) share stimulus and are
// compared every cycle against an array-based model, with literal spot checks.
module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = 5;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NRD*AW-1:0]   rs_addr;
   logic [NWR-1:0]      we;
   logic [NWR*AW-1:0]   rd_addr;
   logic [NWR*XLEN-1:0] rd_data;
   logic                alloc_valid;
   logic [AW-1:0]       alloc_addr;

   logic [NRD*XLEN-1:0] rs_data_b, rs_data_n;
   logic [NRD-1:0]      rs_busy_b, rs_busy_n;
   logic                ready_b, ready_n;

   int nchk = 0;
   int nerr = 0;

   // model state
   logic [XLEN-1:0] mregs [NREGS];
   bit              mbusy [NREGS];
   bit              mready;
   int              mcnt;

   always #5 clk = ~clk;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_byp (
      .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
      .we(we), .rd_addr(rd_addr), .rd_data(rd_data), .alloc_valid(alloc_valid),
      .alloc_addr(alloc_addr), .ready(ready_b));

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_nob (
      .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data_n), .rs_busy(rs_busy_n),
      .we(we), .rd_addr(rd_addr), .rd_data(rd_data), .alloc_valid(alloc_valid),
      .alloc_addr(alloc_addr), .ready(ready_n));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [XLEN-1:0] exp_data(input bit byp, input int i);
      logic [AW-1:0] a;
      a = rs_addr[i*AW +: AW];
      if (!mready || a == 0) return '0;
      if (byp) begin
         for (int j = NWR - 1; j >= 0; j--)
            if (we[j] && rd_addr[j*AW +: AW] == a) return rd_data[j*XLEN +: XLEN];
      end
      return mregs[a];
   endfunction

   function automatic logic exp_busy(input int i);
      logic [AW-1:0] a;
      a = rs_addr[i*AW +: AW];
      if (!mready || a == 0) return 1'b0;
      return mbusy[a];
   endfunction

   // model update: ready after NREGS edges, array zero after sweep, writes ordered by port
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcnt   = 0;
         mready = 0;
      end else if (!mready) begin
         mcnt++;
         if (mcnt == NREGS) begin
            mready = 1;
            for (int r = 0; r < NREGS; r++) begin
               mregs[r] = '0;
               mbusy[r] = 0;
            end
         end
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (we[j] && rd_addr[j*AW +: AW] != 0) mregs[rd_addr[j*AW +: AW]] = rd_data[j*XLEN +: XLEN];
            if (we[j]) mbusy[rd_addr[j*AW +: AW]] = 0;
         end
         if (alloc_valid && alloc_addr != 0) mbusy[alloc_addr] = 1;
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("ready_byp", {31'b0, ready_b}, {31'b0, mready});
         check("ready_nob", {31'b0, ready_n}, {31'b0, mready});
         for (int i = 0; i < NRD; i++) begin
            check("data_byp", rs_data_b[i*XLEN +: XLEN], exp_data(1, i));
            check("data_nob", rs_data_n[i*XLEN +: XLEN], exp_data(0, i));
            check("busy_byp", {31'b0, rs_busy_b[i]}, {31'b0, exp_busy(i)});
            check("busy_nob", {31'b0, rs_busy_n[i]}, {31'b0, exp_busy(i)});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = '0; rd_addr = '0; rd_data = '0; alloc_valid = 0; alloc_addr = '0;
   endtask

   task automatic set_rs(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rs_addr = {a1, a0};
   endtask

   task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      we[j] = 1'b1;
      rd_addr[j*AW +: AW] = a;
      rd_data[j*XLEN +: XLEN] = d;
   endtask

   initial begin
      rst_n = 1'b0;
      rs_addr = '0;
      idle();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: sweep length and cleared contents
      check("ready_reset", {31'b0, ready_b}, 32'd0);
      for (int k = 1; k <= NREGS; k++) begin
         set_wr(0, 5'd4, 32'hBAD0_0000 + k);
         tick();
         if (k == NREGS - 1) check("ready_edge31", {31'b0, ready_b}, 32'd0);
      end
      idle();
      check("ready_edge32", {31'b0, ready_b}, 32'd1);
      for (int a = 1; a < NREGS; a++) begin
         set_rs(AW'(a), AW'(NREGS - a));
         #1 check("sweep_zero", rs_data_b[XLEN-1:0], 32'd0);
         tick();
      end

      // 2: bypass vs no bypass
      set_rs(5'd5, 5'd5);
      set_wr(0, 5'd5, 32'hDEADBEEF);
      #1;
      check("t2_byp_same", rs_data_b[XLEN-1:0], 32'hDEADBEEF);
      check("t2_nob_same", rs_data_n[XLEN-1:0], 32'h0);
      tick(); idle(); #1;
      check("t2_nob_next", rs_data_n[XLEN-1:0], 32'hDEADBEEF);

      // 3: colliding writes, port 1 wins
      tick();
      set_rs(5'd7, 5'd7);
      set_wr(0, 5'd7, 32'h11);
      set_wr(1, 5'd7, 32'h22);
      #1;
      check("t3_byp_p0", rs_data_b[XLEN-1:0], 32'h22);
      check("t3_byp_p1", rs_data_b[2*XLEN-1:XLEN], 32'h22);
      tick(); idle(); #1;
      check("t3_nob_p0", rs_data_n[XLEN-1:0], 32'h22);
      check("t3_nob_p1", rs_data_n[2*XLEN-1:XLEN], 32'h22);

      // 4: x0 is immutable and never busy
      tick();
      set_rs(5'd0, 5'd0);
      set_wr(0, 5'd0, 32'hFFFFFFFF);
      alloc_valid = 1; alloc_addr = 5'd0;
      #1 check("t4_x0_same", rs_data_b[XLEN-1:0], 32'h0);
      tick(); idle(); #1;
      check("t4_x0_data", rs_data_n[XLEN-1:0], 32'h0);
      check("t4_x0_busy", {30'b0, rs_busy_b}, 32'h0);

      // 5: scoreboard set / alloc-wins / clear
      set_rs(5'd3, 5'd3);
      alloc_valid = 1; alloc_addr = 5'd3;
      #1 check("t5_busy_before", {31'b0, rs_busy_b[0]}, 32'd0);
      tick(); idle(); #1;
      check("t5_busy_set", {31'b0, rs_busy_b[0]}, 32'd1);
      set_wr(0, 5'd3, 32'h33);
      alloc_valid = 1; alloc_addr = 5'd3;
      tick(); idle(); #1;
      check("t5_alloc_wins", {31'b0, rs_busy_n[1]}, 32'd1);
      set_wr(1, 5'd3, 32'h44);
      #1 check("t5_busy_no_bypass", {31'b0, rs_busy_b[0]}, 32'd1);
      tick(); idle(); #1;
      check("t5_busy_clear", {31'b0, rs_busy_b[0]}, 32'd0);
      check("t5_data", rs_data_n[XLEN-1:0], 32'h44);

      // mixed traffic checked by the model
      for (int c = 0; c < 60; c++) begin
         we = NWR'($urandom_range(0, 3));
         rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
         rd_data = {32'($urandom), 32'($urandom)};
         alloc_valid = 1'($urandom_range(0, 1));
         alloc_addr = AW'($urandom_range(0, 7));
         set_rs(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
         tick();
      end
      idle();

      // 6: reset in the middle of RUN
      set_wr(0, 5'd9, 32'h1234);
      alloc_valid = 1; alloc_addr = 5'd9;
      tick(); idle();
      set_rs(5'd9, 5'd9);
      #1;
      check("t6_pre_data", rs_data_b[XLEN-1:0], 32'h1234);
      check("t6_pre_busy", {31'b0, rs_busy_b[0]}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("t6_rst_ready", {31'b0, ready_b}, 32'd0);
      check("t6_rst_data", rs_data_b[XLEN-1:0], 32'h0);
      check("t6_rst_busy", {30'b0, rs_busy_n | rs_busy_b}, 32'h0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int k = 1; k <= NREGS; k++) begin
         set_wr(0, 5'd9, 32'h5555);
         alloc_valid = 1; alloc_addr = 5'd9;
         tick();
         if (k == NREGS - 1) check("t6_ready_edge31", {31'b0, ready_n}, 32'd0);
      end
      idle();
      #1;
      check("t6_ready", {31'b0, ready_b}, 32'd1);
      check("t6_x9_data", rs_data_b[XLEN-1:0], 32'h0);
      check("t6_x9_busy", {31'b0, rs_busy_b[0]}, 32'd0);
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end

endmodule
